jt12_op_seq: RTL and testbench

- Slot sequencer and connection controller for the 4-operator FM datapath (jt12_op).
- Walks the 24-slot frame of 6 voices × 4 operators and drives the operator's per-slot inputs: s1..s4_enters, zero, use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y and fb_II.
- Holds the per-channel algorithm and feedback configuration, written through a simple register port.

---
 rtl/jt12_pkg.sv | 41 ++++
 rtl/jt12_op_seq_if.sv | 45 ++++
 rtl/jt12_alg_dec.sv | 43 ++++
 rtl/jt12_op_seq.sv | 100 ++++++++++
 tb/tb_jt12_op_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/jt12_pkg.sv
// Shared slot-frame constants and helpers for the jt12 operator sequencer family.
package jt12_pkg;

    localparam int unsigned SLOTS = 24;
    localparam int unsigned CFG_W = 3;

    // Slot groups follow the frame walk order S1, S3, S2, S4
    localparam logic [1:0] GRP_S1 = 2'd0;
    localparam logic [1:0] GRP_S3 = 2'd1;
    localparam logic [1:0] GRP_S2 = 2'd2;
    localparam logic [1:0] GRP_S4 = 2'd3;

    function automatic logic [1:0] slot_grp(input logic [4:0] c);
        if (c < 5'd6) return GRP_S1;
        else if (c < 5'd12) return GRP_S3;
        else if (c < 5'd18) return GRP_S2;
        else return GRP_S4;
    endfunction

    function automatic logic [2:0] slot_ch(input logic [4:0] c);
        logic [4:0] r;
        case (slot_grp(c))
            GRP_S1:  r = c;
            GRP_S3:  r = c - 5'd6;
            GRP_S2:  r = c - 5'd12;
            default: r = c - 5'd18;
        endcase
        return 3'(r);
    endfunction

    // Operator number (0=S1..3=S4) from frame group
    function automatic logic [1:0] grp_op(input logic [1:0] g);
        case (g)
            GRP_S1:  return 2'd0;
            GRP_S3:  return 2'd2;
            GRP_S2:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/jt12_op_seq_if.sv
// Config write port and per-slot operator controls of jt12_op_seq.
// JT12_OP_SEQ_SLOT_EN adds the slot_ch/slot_op probe signals.
interface jt12_op_seq_if;
    import jt12_pkg::*;

    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [CFG_W-1:0] cfg_alg;
    logic [CFG_W-1:0] cfg_fb;

    logic             s1_enters;
    logic             s2_enters;
    logic             s3_enters;
    logic             s4_enters;
    logic             zero;
    logic             use_prevprev1;
    logic             use_prev1;
    logic             use_prev2;
    logic             use_internal_x;
    logic             use_internal_y;
    logic [CFG_W-1:0] fb_II;
`ifdef JT12_OP_SEQ_SLOT_EN
    logic [2:0]       slot_ch;
    logic [1:0]       slot_op;
`endif

    modport master (
`ifdef JT12_OP_SEQ_SLOT_EN
        input  slot_ch, slot_op,
`endif
        output cfg_we, cfg_ch, cfg_alg, cfg_fb,
        input  s1_enters, s2_enters, s3_enters, s4_enters, zero,
        input  use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y, fb_II
    );

    modport slave (
`ifdef JT12_OP_SEQ_SLOT_EN
        output slot_ch, slot_op,
`endif
        input  cfg_we, cfg_ch, cfg_alg, cfg_fb,
        output s1_enters, s2_enters, s3_enters, s4_enters, zero,
        output use_prevprev1, use_prev1, use_prev2, use_internal_x, use_internal_y, fb_II
    );

endinterface

// File: rtl/jt12_alg_dec.sv
// Combinational decode of FM algorithm and slot group into operator input-mux selects.
module jt12_alg_dec
    import jt12_pkg::*;
(
    input  logic [CFG_W-1:0] alg,
    input  logic [1:0]       grp,
    output logic             use_prevprev1,
    output logic             use_prev1,
    output logic             use_prev2,
    output logic             use_internal_x,
    output logic             use_internal_y
);

    always_comb begin
        use_prevprev1  = 1'b0;
        use_prev1      = 1'b0;
        use_prev2      = 1'b0;
        use_internal_x = 1'b0;
        use_internal_y = 1'b0;
        case (grp)
            GRP_S1: begin
                use_prevprev1 = 1'b1;
                use_prev1     = 1'b1;
            end
            GRP_S3: begin
                use_prevprev1 = (alg == 3'd5);
                use_prev2     = (alg <= 3'd2);
                use_prev1     = (alg == 3'd1);
            end
            GRP_S2: begin
                use_prev1 = (alg == 3'd0) || (alg == 3'd3) || (alg == 3'd4) ||
                            (alg == 3'd5) || (alg == 3'd6);
            end
            default: begin
                use_prev2      = (alg == 3'd3);
                use_internal_x = (alg == 3'd2);
                use_internal_y = (alg <= 3'd4) && (alg != 3'd2);
                use_prev1      = (alg == 3'd5);
            end
        endcase
    end

endmodule

// File: rtl/jt12_op_seq.sv
// 24-slot operator sequencer with per-channel algorithm/feedback registers.
// Optional JT12_OP_SEQ_SLOT_EN exposes slot_ch/slot_op probe outputs.
module jt12_op_seq
    import jt12_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    jt12_op_seq_if.slave  seq
);

    if (4 * NUM_VOICES != SLOTS) begin : g_bad_voices
        $error("jt12_op_seq supports only NUM_VOICES = 6");
    end

    logic [4:0]       cnt_q;
    logic [4:0]       cnt_nx;
    logic [1:0]       grp_nx;
    logic [2:0]       ch_nx;
    logic [2:0]       ch_cur;
    logic             leave_s1;
    logic [CFG_W-1:0] alg_q [NUM_VOICES];
    logic [CFG_W-1:0] fb_q  [NUM_VOICES];
    logic [CFG_W-1:0] alg_nx;
    logic             dec_pp1, dec_p1, dec_p2, dec_ix, dec_iy;

    // Outputs are decoded from the slot being entered, so they describe cnt_q after the edge
    always_comb begin
        cnt_nx   = (cnt_q == 5'(SLOTS - 1)) ? 5'd0 : cnt_q + 5'd1;
        grp_nx   = slot_grp(cnt_nx);
        ch_nx    = slot_ch(cnt_nx);
        alg_nx   = alg_q[ch_nx];
        ch_cur   = slot_ch(cnt_q);
        leave_s1 = (slot_grp(cnt_q) == GRP_S1);
    end

    jt12_alg_dec u_alg_dec (
        .alg            (alg_nx),
        .grp            (grp_nx),
        .use_prevprev1  (dec_pp1),
        .use_prev1      (dec_p1),
        .use_prev2      (dec_p2),
        .use_internal_x (dec_ix),
        .use_internal_y (dec_iy)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q              <= '0;
            seq.s1_enters      <= 1'b1;
            seq.s2_enters      <= 1'b0;
            seq.s3_enters      <= 1'b0;
            seq.s4_enters      <= 1'b0;
            seq.zero           <= 1'b1;
            seq.use_prevprev1  <= 1'b1;
            seq.use_prev1      <= 1'b1;
            seq.use_prev2      <= 1'b0;
            seq.use_internal_x <= 1'b0;
            seq.use_internal_y <= 1'b0;
            seq.fb_II          <= '0;
`ifdef JT12_OP_SEQ_SLOT_EN
            seq.slot_ch        <= '0;
            seq.slot_op        <= '0;
`endif
        end else if (clk_en) begin
            cnt_q              <= cnt_nx;
            seq.s1_enters      <= (grp_nx == GRP_S1);
            seq.s2_enters      <= (grp_nx == GRP_S2);
            seq.s3_enters      <= (grp_nx == GRP_S3);
            seq.s4_enters      <= (grp_nx == GRP_S4);
            seq.zero           <= (cnt_nx == 5'd0);
            seq.use_prevprev1  <= dec_pp1;
            seq.use_prev1      <= dec_p1;
            seq.use_prev2      <= dec_p2;
            seq.use_internal_x <= dec_ix;
            seq.use_internal_y <= dec_iy;
            seq.fb_II          <= leave_s1 ? fb_q[ch_cur] : '0;
`ifdef JT12_OP_SEQ_SLOT_EN
            seq.slot_ch        <= ch_nx;
            seq.slot_op        <= grp_op(grp_nx);
`endif
        end
    end

    // A write landing on a slot of the same channel only affects later slots
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
                alg_q[i] <= '0;
                fb_q[i]  <= '0;
            end
        end else if (clk_en && seq.cfg_we && (seq.cfg_ch < 3'(NUM_VOICES))) begin
            alg_q[seq.cfg_ch] <= seq.cfg_alg;
            fb_q[seq.cfg_ch]  <= seq.cfg_fb;
        end
    end

endmodule

// File: tb/tb_jt12_op_seq.sv
// Randomized and directed bench for jt12_op_seq against a slot-level reference model.
module tb_jt12_op_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clk_en = 1'b0;

    always #5 clk = ~clk;

    jt12_op_seq_if bus ();

    jt12_op_seq #(.NUM_VOICES(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .seq    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: slot index, channel config, expected output word
    int          m_cnt;
    int          m_alg [6];
    int          m_fb  [6];
    int          m_fbii;
    logic [12:0] m_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (slot %0d)", tag, got, exp, m_cnt);
        end
    endtask

    // {s1,s2,s3,s4,zero,prevprev1,prev1,prev2,int_x,int_y,fb_II}
    function automatic logic [12:0] model_out(input int c, input int fbv);
        int   g;
        int   a;
        logic s1, s2, s3, s4, pp1, p1, p2, ix, iy;
        g   = c / 6;
        a   = m_alg[c % 6];
        s1  = (g == 0);
        s3  = (g == 1);
        s2  = (g == 2);
        s4  = (g == 3);
        pp1 = s1 || (s3 && a == 5);
        p2  = (s3 && a <= 2) || (s4 && a == 3);
        ix  = s4 && a == 2;
        iy  = s4 && a <= 4 && a != 2;
        p1  = s1 || (s3 && a == 1) ||
              (s2 && (a == 0 || a == 3 || a == 4 || a == 5 || a == 6)) || (s4 && a == 5);
        return {s1, s2, s3, s4, (c == 0), pp1, p1, p2, ix, iy, 3'(fbv)};
    endfunction

    function automatic logic [12:0] dut_out();
        return {bus.s1_enters, bus.s2_enters, bus.s3_enters, bus.s4_enters, bus.zero,
                bus.use_prevprev1, bus.use_prev1, bus.use_prev2, bus.use_internal_x,
                bus.use_internal_y, bus.fb_II};
    endfunction

    task automatic step(input logic en, input logic we, input logic [2:0] ch,
                        input logic [2:0] a, input logic [2:0] f);
        clk_en      = en;
        bus.cfg_we  = we;
        bus.cfg_ch  = ch;
        bus.cfg_alg = a;
        bus.cfg_fb  = f;
        @(posedge clk);
        #1;
        if (!rst) begin
            m_cnt  = 0;
            m_fbii = 0;
            for (int i = 0; i < 6; i++) begin
                m_alg[i] = 0;
                m_fb[i]  = 0;
            end
            m_out = model_out(0, 0);
        end else if (en) begin
            m_fbii = (m_cnt < 6) ? m_fb[m_cnt] : 0;
            m_cnt  = (m_cnt + 1) % 24;
            m_out  = model_out(m_cnt, m_fbii);
            if (we && ch < 6) begin
                m_alg[ch] = int'(a);
                m_fb[ch]  = int'(f);
            end
        end
        check("outputs", 32'(dut_out()), 32'(m_out));
`ifdef JT12_OP_SEQ_SLOT_EN
        check("slot_ch", 32'(bus.slot_ch), 32'(m_cnt % 6));
        check("slot_op", 32'(bus.slot_op),
              (m_cnt / 6 == 1) ? 32'd2 : (m_cnt / 6 == 2) ? 32'd1 : 32'(m_cnt / 6));
`endif
    endtask

    task automatic idle_to(input int target);
        for (int i = 0; i < 24 && m_cnt != target; i++) step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        check("reach_slot", 32'(m_cnt), 32'(target));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0);
        rst = 1'b1;
    endtask

    int zero_hits;

    initial begin
        m_cnt = 0;
        // Reset with clk_en low still takes effect
        do_reset();
        check("rst_zero", 32'(bus.zero), 32'd1);
        check("rst_s1", 32'(bus.s1_enters), 32'd1);

        zero_hits = 0;
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
            if (bus.zero === 1'b1) zero_hits++;
        end
        check("zero_twice_in_48", 32'(zero_hits), 32'd2);

        // ch2 alg 0 / fb 5, then one frame with directed spot checks
        step(1'b1, 1'b1, 3'd2, 3'd0, 3'd5);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
            if (m_cnt == 14) check("s2_ch2_prev1", 32'(bus.use_prev1), 32'd1);
            if (m_cnt == 8)  check("s3_ch2_prev2", 32'(bus.use_prev2), 32'd1);
            if (m_cnt == 20) check("s4_ch2_int_y", 32'(bus.use_internal_y), 32'd1);
            if (m_cnt == 3)  check("fb_after_s1_ch2", 32'(bus.fb_II), 32'd5);
        end

        // Algorithm sweep on ch0
        for (int a = 0; a < 8; a++) begin
            idle_to(23);
            step(1'b1, 1'b1, 3'd0, 3'(a), 3'(a));
            for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        end

        // 50% clk_en duty
        for (int i = 0; i < 96; i++) step(1'(i % 2), 1'b0, 3'd0, 3'd0, 3'd0);

        // Same-edge write hazard on ch4
        do_reset();
        idle_to(9);
        step(1'b1, 1'b1, 3'd4, 3'd5, 3'd0);
        check("hazard_old_prev2", 32'(bus.use_prev2), 32'd1);
        check("hazard_old_pp1", 32'(bus.use_prevprev1), 32'd0);
        for (int i = 0; i < 24; i++) step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
        check("hazard_new_pp1", 32'(bus.use_prevprev1), 32'd1);
        check("hazard_new_prev2", 32'(bus.use_prev2), 32'd0);

        // Reset mid-frame with a write pending
        step(1'b1, 1'b1, 3'd1, 3'd3, 3'd7);
        idle_to(17);
        rst = 1'b0;
        step(1'b1, 1'b1, 3'd1, 3'd3, 3'd7);
        rst = 1'b1;
        check("midrst_zero", 32'(bus.zero), 32'd1);
        check("midrst_s1", 32'(bus.s1_enters), 32'd1);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0);
            if (m_cnt == 2) check("midrst_fb_cleared", 32'(bus.fb_II), 32'd0);
            if (m_cnt == 7) check("midrst_alg_cleared", 32'(bus.use_prev2), 32'd1);
        end

        // Random traffic including out-of-range channels
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
